idex_pipeline_reg: RTL and testbench
====================================

# idex_pipeline_reg

ID/EX pipeline register of the 5-stage RV32I core. It captures decoded operands, immediate and control bits from ID and presents them to EX. It consumes the stall and bubble controls produced by `hazard_detection_unit` and returns the `IDEX_Rd` / `IDEX_MemRead` values that unit compares against. It also supports a branch/jump flush from EX and an optional bubble/flush performance counter.

## Interface
- `XLEN`, 32, datapath width (pc, operands, immediate).
- `REG_AW`, 5, register-address width.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IDEX_write`  in  1  load enable from the hazard unit; 0 = hold.
- `control_MuxSel`  in  1  from the hazard unit; 1 = insert a bubble (NOP).
- `flush`  in  1  from EX branch resolution; 1 = kill the instruction entering EX.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN each  ID datapath values.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_AW each  register addresses.
- `id_funct3`  in  3  funct3 field.
- `id_funct7b5`  in  1  instruction bit 30.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src`, `id_branch`, `id_jump`  in  1 each  control bits.
- `id_alu_op`  in  2  ALU-op class.
- `ex_*`  out  same widths as the `id_*` inputs  registered copies, including `ex_valid`.
- `IDEX_Rd`  out  REG_AW  alias of `ex_rd`, fed to the hazard unit.
- `IDEX_MemRead`  out  1  alias of `ex_mem_read`, fed to the hazard unit.
- `bubble_count`, `flush_count`  out  32 each  present only when the performance-counter macro is defined.

## Operation
Fields fall into two groups:
- **Control group:** `valid`, `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `alu_src`, `branch`, `jump`, `alu_op`, `rd`.
- **Data group:** `pc`, `rs1_data`, `rs2_data`, `imm`, `rs1`, `rs2`, `funct3`, `funct7b5`.

Each edge applies exactly one action, in this priority order:
1. **Flush** (`flush`=1): control group cleared to 0. Data group holds.
2. **Bubble** (`control_MuxSel`=1): control group cleared to 0, including `rd`=0, so the hazard unit cannot re-match. Data group holds. A bubble is applied even when `IDEX_write`=0.
3. **Hold** (`IDEX_write`=0): all fields hold.
4. **Load** (otherwise): all fields take their `id_*` values.

Additional rules:
- An instruction with `id_valid`=0 loads its control group as 0, whatever the `id_*` control inputs are.
- Both `IDEX_Rd` and `IDEX_MemRead` are zero whenever `ex_valid`=0.
- A bubble always leaves an all-zero control group, i.e. a canonical NOP (equivalent to addi x0,x0,0 with no side effects).

## Timing
- Latency: exactly one cycle from the ID inputs to the EX outputs; no combinational path from input to output.
- Reset: every output, and every counter, is 0 while `rst`=1. Reset is asserted asynchronously; deassertion is synchronous to `clk` and handled externally.
- Reset asserted mid-stall: the register empties. After release, the first edge performs a normal priority evaluation.
- Load-use sequence: a load is in EX and the hazard unit asserts `control_MuxSel`. On the next edge EX receives a bubble while the dependent instruction waits in IF/ID. On the edge after that the dependent instruction loads normally.
- Simultaneous `flush` and `control_MuxSel`: flush wins. `flush_count` increments and `bubble_count` does not.
- Back-to-back bubbles are legal; each is counted.

## Configuration
Macro: `IDEX_PERF_CNT_EN`.
- **Defined:** `bubble_count` increments on every edge that applies a bubble. `flush_count` increments on every edge that applies a flush. Both are 32-bit, wrap modulo 2^32, and are cleared only by `rst`.
- **Undefined:** the counter ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared `core_pkg` holds:
  - the `XLEN` and `REG_AW` constants;
  - the `alu_op` encodings: 00 add/load-store, 01 branch compare, 10 R-type, 11 I-type;
  - a packed `ctrl_t` struct for the control group, with a `CTRL_NOP` constant of all zeros.
- One sub-module, `pipe_field_reg`: a parameterised-width register with async reset, a load enable and a synchronous clear.
  - It is instantiated once for the control group (clear = flush | bubble) and once for the data group (clear tied off).

## Test plan
- **Reset:** assert `rst` mid-cycle with the register loaded and `id_mem_read`=1 → all outputs are 0 immediately, before the next edge.
- **Normal load:** `id_rd`=5, `id_mem_read`=1, `id_imm`=0x10, `IDEX_write`=1 → next edge `IDEX_Rd`=5, `IDEX_MemRead`=1, `ex_imm`=0x10.
- **Load-use:** `control_MuxSel`=1 with `IDEX_write`=0 and `id_rd`=7 → next edge `ex_valid`=0, `IDEX_Rd`=0, `IDEX_MemRead`=0, data fields unchanged; `bubble_count`=1 when the macro is defined.
- **Plain hold:** `IDEX_write`=0, `control_MuxSel`=0, with the inputs changed → all outputs unchanged for 3 cycles.
- **Simultaneous events:** `flush`=1 and `control_MuxSel`=1 on the same edge → control group 0, `flush_count`=1, `bubble_count`=0.
- **Counter wrap:** preload `bubble_count` to 0xFFFFFFFF by force, then apply one bubble → counter reads 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
// Control/data bundles used by the ID/EX pipeline register.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              branch;
    logic              jump;
    alu_op_e           alu_op;
    logic [REG_AW-1:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
  } data_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async reset,
// load enable, synchronous clear (clear wins).
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  // next state: clear, else load, else hold
  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (en)
      q_d = d;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register with flush/bubble/hold/load priority.
// Optional bubble/flush counters under IDEX_PERF_CNT_EN.
module idex_pipeline_reg
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              IDEX_write,
  input  logic              control_MuxSel,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [1:0]        id_alu_op,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] IDEX_Rd,
  output logic              IDEX_MemRead
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_count,
  output logic [31:0]       flush_count
`endif
);

  ctrl_t ctrl_in, ctrl_out;
  data_t data_in, data_out;
  logic  kill;
  logic  data_en;

  assign kill    = flush | control_MuxSel;
  assign data_en = IDEX_write & ~kill;

  // invalid ID slots enter EX as a canonical NOP
  always_comb begin
    ctrl_in = CTRL_NOP;
    if (id_valid) begin
      ctrl_in.valid      = 1'b1;
      ctrl_in.reg_write  = id_reg_write;
      ctrl_in.mem_read   = id_mem_read;
      ctrl_in.mem_write  = id_mem_write;
      ctrl_in.mem_to_reg = id_mem_to_reg;
      ctrl_in.alu_src    = id_alu_src;
      ctrl_in.branch     = id_branch;
      ctrl_in.jump       = id_jump;
      ctrl_in.alu_op     = alu_op_e'(id_alu_op);
      ctrl_in.rd         = id_rd;
    end
  end

  assign data_in = '{
    pc:       id_pc,
    rs1_data: id_rs1_data,
    rs2_data: id_rs2_data,
    imm:      id_imm,
    rs1:      id_rs1,
    rs2:      id_rs2,
    funct3:   id_funct3,
    funct7b5: id_funct7b5
  };

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (IDEX_write),
    .clr (kill),
    .d   (ctrl_in),
    .q   (ctrl_out)
  );

  pipe_field_reg #(.W($bits(data_t))) u_data (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .clr (1'b0),
    .d   (data_in),
    .q   (data_out)
  );

  assign ex_valid      = ctrl_out.valid;
  assign ex_reg_write  = ctrl_out.reg_write;
  assign ex_mem_read   = ctrl_out.mem_read;
  assign ex_mem_write  = ctrl_out.mem_write;
  assign ex_mem_to_reg = ctrl_out.mem_to_reg;
  assign ex_alu_src    = ctrl_out.alu_src;
  assign ex_branch     = ctrl_out.branch;
  assign ex_jump       = ctrl_out.jump;
  assign ex_alu_op     = ctrl_out.alu_op;
  assign ex_rd         = ctrl_out.rd;

  assign ex_pc       = data_out.pc;
  assign ex_rs1_data = data_out.rs1_data;
  assign ex_rs2_data = data_out.rs2_data;
  assign ex_imm      = data_out.imm;
  assign ex_rs1      = data_out.rs1;
  assign ex_rs2      = data_out.rs2;
  assign ex_funct3   = data_out.funct3;
  assign ex_funct7b5 = data_out.funct7b5;

  // control group is all-zero whenever valid is 0
  assign IDEX_Rd      = ctrl_out.rd;
  assign IDEX_MemRead = ctrl_out.mem_read;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // flush outranks bubble, so only one counter steps per edge
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush)
      flush_cnt_d = flush_cnt_q + 32'd1;
    else if (control_MuxSel)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // counter registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// Randomised self-checking bench for idex_pipeline_reg.
// Reference model tracks expected EX fields per edge.
module tb_idex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        IDEX_write, control_MuxSel, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_alu_src, id_branch, id_jump;
  logic [1:0]  id_alu_op;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump;
  logic [1:0]  ex_alu_op;
  logic [4:0]  IDEX_Rd;
  logic        IDEX_MemRead;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_count, flush_count;
`endif

  int n_tot = 0;
  int n_bad = 0;

  // model state: control {valid,rw,mr,mw,m2r,src,br,j,op,rd}
  logic [14:0]  m_ctl;
  logic [141:0] m_dat;
  logic [31:0]  m_bub, m_fl;

  always #5 clk = ~clk;

  idex_pipeline_reg dut (
    .clk            (clk),
    .rst            (rst),
    .IDEX_write     (IDEX_write),
    .control_MuxSel (control_MuxSel),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_funct3      (id_funct3),
    .id_funct7b5    (id_funct7b5),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_mem_to_reg  (id_mem_to_reg),
    .id_alu_src     (id_alu_src),
    .id_branch      (id_branch),
    .id_jump        (id_jump),
    .id_alu_op      (id_alu_op),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_funct3      (ex_funct3),
    .ex_funct7b5    (ex_funct7b5),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_alu_src     (ex_alu_src),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_alu_op      (ex_alu_op),
    .IDEX_Rd        (IDEX_Rd),
    .IDEX_MemRead   (IDEX_MemRead)
`ifdef IDEX_PERF_CNT_EN
    ,
    .bubble_count   (bubble_count),
    .flush_count    (flush_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] id_ctl();
    return {1'b1, id_reg_write, id_mem_read, id_mem_write,
            id_mem_to_reg, id_alu_src, id_branch, id_jump,
            id_alu_op, id_rd};
  endfunction

  function automatic logic [141:0] id_dat();
    return {id_pc, id_rs1_data, id_rs2_data, id_imm,
            id_rs1, id_rs2, id_funct3, id_funct7b5};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ctl"},
        {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump,
         ex_alu_op, ex_rd}, m_ctl);
    chk({tag, ".dat"},
        {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
         ex_rs1, ex_rs2, ex_funct3, ex_funct7b5}, m_dat);
    chk({tag, ".hz"}, {IDEX_Rd, IDEX_MemRead},
        {m_ctl[4:0], m_ctl[12]});
`ifdef IDEX_PERF_CNT_EN
    chk({tag, ".bub"}, bubble_count, m_bub);
    chk({tag, ".fl"}, flush_count, m_fl);
`endif
  endtask

  task automatic mdl_reset();
    m_ctl = '0;
    m_dat = '0;
    m_bub = '0;
    m_fl  = '0;
  endtask

  // one edge of the reference: flush > bubble > hold > load
  task automatic mdl_edge();
    if (flush) begin
      m_ctl = '0;
      m_fl  = m_fl + 1;
    end else if (control_MuxSel) begin
      m_ctl = '0;
      m_bub = m_bub + 1;
    end else if (IDEX_write) begin
      m_dat = id_dat();
      m_ctl = id_valid ? id_ctl() : 15'd0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    mdl_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rnd_in();
    id_valid      = ($urandom_range(3) != 0);
    id_pc         = $urandom;
    id_rs1_data   = $urandom;
    id_rs2_data   = $urandom;
    id_imm        = $urandom;
    id_rs1        = 5'($urandom);
    id_rs2        = 5'($urandom);
    id_rd         = 5'($urandom);
    id_funct3     = 3'($urandom);
    id_funct7b5   = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    id_alu_src    = 1'($urandom);
    id_branch     = 1'($urandom);
    id_jump       = 1'($urandom);
    id_alu_op     = 2'($urandom);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    mdl_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    IDEX_write = 1'b0;
    control_MuxSel = 1'b0;
    flush = 1'b0;
    rnd_in();
    mdl_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // normal load
    rnd_in();
    id_valid = 1'b1;
    id_rd = 5'd5;
    id_mem_read = 1'b1;
    id_imm = 32'h10;
    IDEX_write = 1'b1;
    tick("load");
    chk("load.rd", IDEX_Rd, 5'd5);
    chk("load.mr", IDEX_MemRead, 1'b1);
    chk("load.imm", ex_imm, 32'h10);

    // reset mid-cycle with a load in EX
    async_reset("rst_mid");

    // reload then load-use bubble with write disabled
    rnd_in();
    id_valid = 1'b1;
    id_mem_read = 1'b1;
    IDEX_write = 1'b1;
    tick("reload");
    rnd_in();
    id_rd = 5'd7;
    IDEX_write = 1'b0;
    control_MuxSel = 1'b1;
    tick("bubble");
    chk("bubble.v", ex_valid, 1'b0);
    chk("bubble.rd", IDEX_Rd, 5'd0);
    control_MuxSel = 1'b0;
    IDEX_write = 1'b1;
    tick("dep_load");

    // plain hold for 3 cycles with changing inputs
    IDEX_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      tick("hold");
    end

    // flush and bubble together
    rnd_in();
    IDEX_write = 1'b1;
    flush = 1'b1;
    control_MuxSel = 1'b1;
    tick("flush_bub");
    flush = 1'b0;
    control_MuxSel = 1'b0;

    // reset during a stall, then normal first edge
    IDEX_write = 1'b0;
    control_MuxSel = 1'b1;
    tick("stall");
    async_reset("rst_stall");
    control_MuxSel = 1'b0;
    IDEX_write = 1'b1;
    rnd_in();
    tick("post_rst");

`ifdef IDEX_PERF_CNT_EN
    // counter wrap
    @(negedge clk);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt_q;
    m_bub = 32'hFFFF_FFFF;
    control_MuxSel = 1'b1;
    tick("wrap");
    chk("wrap.cnt", bubble_count, 32'd0);
    control_MuxSel = 1'b0;
`endif

    // randomised mix
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      IDEX_write     = ($urandom_range(3) != 0);
      control_MuxSel = ($urandom_range(4) == 0);
      flush          = ($urandom_range(9) == 0);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
